// File: rtl/map_iterator.sv
// ---------------------------------------------------------------------------
// map_iterator
//   Generates the orbit x_0, x_1, ... of the affine map
//   x_{t+1} = (A*x_t + C) mod 2^W, starting from a loaded seed. Values are
//   streamed one per accepted valid/ready transfer. A run ends after N
//   transfers or on abort, and a one-cycle done pulse marks the end.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : begin a run (honoured only in IDLE)
//   abort         : end a run in progress (honoured only in EMIT)
//   seed          : x_0, latched on accepted start
//   coef_a/coef_c : multiplier A / addend C, latched on accepted start
//   max_iter      : number of values N to emit, latched on accepted start
//   x_out/x_valid : current sequence value and its valid flag
//   x_ready       : downstream accepts x_out this cycle
//   iter_count    : transfers made in the current or last run
//   busy          : high while values are being emitted
//   done          : one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module map_iterator #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  seed,
  input  logic [W-1:0]  coef_a,
  input  logic [W-1:0]  coef_c,
  input  logic [CW-1:0] max_iter,
  output logic [W-1:0]  x_out,
  output logic          x_valid,
  input  logic          x_ready,
  output logic [CW-1:0] iter_count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_x;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_c;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_cnt;

  logic          w_start_ok;
  logic          w_xfer;
  logic [CW-1:0] w_cnt_inc;
  logic          w_last;

  // The low W bits of the full 2W-bit product A*x are exactly the W-bit
  // product, so the modulo-2^W result needs no wider intermediate.
  function automatic logic [W-1:0] affine_step(input logic [W-1:0] a,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] c);
    logic [W-1:0] prod;
    prod = a * x;
    return prod + c;
  endfunction

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_xfer     = (r_state == S_EMIT) && x_ready;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_last     = (w_cnt_inc == r_n);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        // start has priority over abort here: abort is simply not looked at
        if (start) begin
          w_state_nxt = (max_iter == '0) ? S_FIN : S_EMIT;
        end
      end
      S_EMIT: begin
        if (abort || (w_xfer && w_last)) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latches, sequence value and transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_a   <= '0;
      r_c   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_a   <= coef_a;
      r_c   <= coef_c;
      r_n   <= max_iter;
      r_cnt <= '0;
      if (max_iter != '0) begin
        r_x <= seed;
      end
    end else if (w_xfer) begin
      r_cnt <= w_cnt_inc;
      // After the final value or an abort nothing more is produced, so x_out
      // keeps the last transferred value.
      if (!w_last && !abort) begin
        r_x <= affine_step(r_a, r_x, r_c);
      end
    end
  end

  assign x_out      = r_x;
  assign x_valid    = (r_state == S_EMIT);
  assign busy       = (r_state == S_EMIT);
  assign done       = (r_state == S_FIN);
  assign iter_count = r_cnt;

endmodule

// File: tb/tb_map_iterator.sv
module tb_map_iterator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic [7:0] coef_a;
  logic [7:0] coef_c;
  logic [7:0] max_iter;
  logic [7:0] x_out;
  logic       x_valid;
  logic       x_ready;
  logic [7:0] iter_count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  map_iterator #(.W(8), .CW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .coef_a     (coef_a),
    .coef_c     (coef_c),
    .max_iter   (max_iter),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .iter_count (iter_count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [7:0] s;
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] n;
    int         rdy_pct;      // chance (%) of x_ready per cycle
    int         ab_at;        // abort when this many transfers done (-1: never)
    bit         ab_xfer;      // allow a transfer in the abort cycle
    bit         st_mid;       // pulse start during the run
    bit         ab_on_start;  // abort raised together with start in IDLE
    int         exp_cnt;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drives one run and checks it cycle by cycle against the orbit computed
  // directly from the map definition.
  task automatic run_vec(input vec_t v, output int cnt_o, output logic [7:0] last_o);
    logic [7:0] q[$];
    logic [7:0] xm;
    int idx;
    int cyc;
    bit aborted;
    bit rdy;
    bit ab;

    xm = v.s;
    for (int i = 0; i < int'(v.n); i++) begin
      q.push_back(xm);
      xm = 8'((int'(v.a) * int'(xm) + int'(v.c)) % 256);
    end

    @(negedge clk);
    seed = v.s; coef_a = v.a; coef_c = v.c; max_iter = v.n;
    start = 1'b1; abort = v.ab_on_start; x_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    // operands must already be latched; change them to prove it
    seed = 8'($urandom); coef_a = 8'($urandom); coef_c = 8'($urandom);
    max_iter = 8'($urandom);

    idx = 0; cyc = 0; aborted = 1'b0; last_o = 8'd0;
    while (idx < int'(v.n) && !aborted) begin
      chk("emit_valid", {31'd0, x_valid}, 32'd1);
      chk("emit_busy", {31'd0, busy}, 32'd1);
      chk("emit_done", {31'd0, done}, 32'd0);
      chk("emit_x", {24'd0, x_out}, {24'd0, q[idx]});
      chk("emit_cnt", {24'd0, iter_count}, idx);
      rdy = ($urandom_range(99) < v.rdy_pct);
      ab  = (v.ab_at >= 0) && (idx == v.ab_at);
      if (ab && !v.ab_xfer) rdy = 1'b0;
      x_ready = rdy;
      abort   = ab;
      start   = v.st_mid && (cyc == 1);
      if (rdy) begin
        last_o = q[idx];
        idx++;
      end
      if (ab) aborted = 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL run_timeout actual=%0d expected<=%0d", cyc, 3000);
        break;
      end
    end
    x_ready = 1'b0; abort = 1'b0; start = 1'b0;
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_valid", {31'd0, x_valid}, 32'd0);
    chk("fin_busy", {31'd0, busy}, 32'd0);
    chk("fin_cnt", {24'd0, iter_count}, idx);
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_valid", {31'd0, x_valid}, 32'd0);
    chk("idle_cnt", {24'd0, iter_count}, idx);
    cnt_o = idx;
  endtask

  initial begin
    int         cnt;
    logic [7:0] last;
    vec_t       rv;

    //            s     a     c     n    rdy  ab_at xf st  as  cnt last
    vecs[0] = '{8'd3,   8'd5,   8'd1,   8'd4,   100, -1, 0, 0, 0, 4,   8'd150};
    vecs[1] = '{8'd200, 8'd0,   8'd7,   8'd3,   100, -1, 0, 0, 0, 3,   8'd7};
    vecs[2] = '{8'd9,   8'd1,   8'd0,   8'd5,   100, -1, 0, 0, 0, 5,   8'd9};
    vecs[3] = '{8'd42,  8'd3,   8'd3,   8'd0,   100, -1, 0, 0, 0, 0,   8'd0};
    vecs[4] = '{8'd3,   8'd5,   8'd1,   8'd10,  100,  2, 0, 1, 0, 2,   8'd16};
    vecs[5] = '{8'd3,   8'd5,   8'd1,   8'd10,  100,  2, 1, 0, 0, 3,   8'd81};
    vecs[6] = '{8'd255, 8'd255, 8'd255, 8'd3,   100, -1, 0, 0, 1, 3,   8'd255};
    vecs[7] = '{8'd0,   8'd1,   8'd1,   8'd255, 100, -1, 0, 0, 0, 255, 8'd254};
    vecs[8] = '{8'd3,   8'd5,   8'd1,   8'd4,    40, -1, 0, 0, 0, 4,   8'd150};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; x_ready = 1'b0;
    seed = 8'd0; coef_a = 8'd0; coef_c = 8'd0; max_iter = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_x", {24'd0, x_out}, 32'd0);
    chk("rst_valid", {31'd0, x_valid}, 32'd0);
    chk("rst_cnt", {24'd0, iter_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // abort while idle is ignored
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], cnt, last);
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_cnt > 0)
        chk($sformatf("vec%0d_last", i), {24'd0, last}, {24'd0, vecs[i].exp_last});
    end

    // backpressure: x_ready low for 3 cycles while x_out=16
    @(negedge clk);
    seed = 8'd3; coef_a = 8'd5; coef_c = 8'd1; max_iter = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_x0", {24'd0, x_out}, 32'd3);
    x_ready = 1'b1;
    @(negedge clk);
    chk("bp_x1", {24'd0, x_out}, 32'd16);
    x_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_x", {24'd0, x_out}, 32'd16);
      chk("bp_hold_valid", {31'd0, x_valid}, 32'd1);
      chk("bp_hold_cnt", {24'd0, iter_count}, 32'd1);
    end
    x_ready = 1'b1;
    @(negedge clk);
    chk("bp_x2", {24'd0, x_out}, 32'd81);
    chk("bp_cnt2", {24'd0, iter_count}, 32'd2);
    @(negedge clk);
    chk("bp_x3", {24'd0, x_out}, 32'd150);
    chk("bp_cnt3", {24'd0, iter_count}, 32'd3);
    @(negedge clk);
    x_ready = 1'b0;
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_cnt4", {24'd0, iter_count}, 32'd4);
    @(negedge clk);
    chk("bp_done_off", {31'd0, done}, 32'd0);

    // reset mid-run after two transfers
    seed = 8'd3; coef_a = 8'd5; coef_c = 8'd1; max_iter = 8'd10; start = 1'b1;
    x_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mr_x_before", {24'd0, x_out}, 32'd81);
    rst_n = 1'b0;
    #1;
    chk("mr_x", {24'd0, x_out}, 32'd0);
    chk("mr_valid", {31'd0, x_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_cnt", {24'd0, iter_count}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; x_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mr_no_done", {31'd0, done}, 32'd0);
    end
    run_vec(vecs[0], cnt, last);
    chk("mr_fresh_cnt", cnt, 4);
    chk("mr_fresh_last", {24'd0, last}, 32'd150);

    // randomized runs against the orbit model
    for (int r = 0; r < 25; r++) begin
      rv.s = 8'($urandom); rv.a = 8'($urandom); rv.c = 8'($urandom);
      rv.n = 8'($urandom_range(20));
      rv.rdy_pct = int'($urandom_range(100, 30));
      rv.ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(int'(rv.n))) : -1;
      rv.ab_xfer = 1'($urandom_range(1));
      rv.st_mid = 1'($urandom_range(1));
      rv.ab_on_start = 1'($urandom_range(1));
      rv.exp_cnt = 0; rv.exp_last = 8'd0;
      run_vec(rv, cnt, last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
